// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall bus types, stage indices, stall patterns and helpers
//
// Purpose: one place for the stall bus width and type, the pipeline stage
// index names and the canonical stall patterns used by the pipeline
// controller and its priority encoder. The redirect FSM encoding is kept
// local to pipe_ctrl.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 32;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // Bit k of the stall bus holds stage k.
  typedef enum int unsigned {
    STG_PC     = 0,
    STG_IF_ID  = 1,
    STG_ID_EX  = 2,
    STG_EX_MEM = 3,
    STG_MEM_WB = 4,
    STG_WB     = 5
  } stage_e;

  // A stall raised by a stage freezes that stage and everything upstream of
  // it. Write-back never stalls, so bit 5 is zero in every pattern.
  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/stall_prio_enc.sv
// rtl/stall_prio_enc.sv - combinational priority encoder from stage stall requests to stall bus
//
// Purpose: pick the deepest stage that is requesting a stall and emit the
// matching stall pattern. The deepest request wins because it already
// freezes every upstream stage.
// Ports:
//   if_req_i   - fetch not complete
//   id_req_i   - load-use hazard in decode
//   ex_req_i   - multi-cycle execute
//   mem_req_i  - memory access not complete
//   stall_o    - 6-bit stall bus, bit k holds stage k
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic               if_req_i,
  input  logic               id_req_i,
  input  logic               ex_req_i,
  input  logic               mem_req_i,
  output logic [STALL_W-1:0] stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (mem_req_i) begin
      stall_o = STALL_MEM;
    end else if (ex_req_i) begin
      stall_o = STALL_EX;
    end else if (id_req_i) begin
      stall_o = STALL_ID;
    end else if (if_req_i) begin
      stall_o = STALL_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall, flush and branch redirect controller
//
// Purpose: turns per-stage stall requests into the stall bus, squashes the
// front of the pipe on a taken branch, holds the branch redirect until the
// PC stage is free to take it, and keeps stall/flush performance counters.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   if_stall_req      - fetch not complete
//   id_stall_req      - load-use hazard in decode
//   ex_stall_req      - multi-cycle execute
//   mem_stall_req     - memory access not complete
//   ex_b_flag_i       - taken branch/jump resolved in EX
//   ex_b_target_i     - redirect address paired with ex_b_flag_i
//   stall_state       - combinational stall bus, bit k holds stage k
//   flush_o           - squash if_id and id_ex contents
//   redirect_valid_o  - a PC redirect is pending
//   redirect_pc_o     - pending redirect target
//   stall_cycles_o    - saturating count of cycles with any stall
//   flush_count_o     - saturating count of accepted branches
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               mem_stall_req,
  input  logic               ex_b_flag_i,
  input  logic [PC_W-1:0]    ex_b_target_i,
  output logic [STALL_W-1:0] stall_state,
  output logic               flush_o,
  output logic               redirect_valid_o,
  output logic [PC_W-1:0]    redirect_pc_o,
  output logic [CNT_W-1:0]   stall_cycles_o,
  output logic [CNT_W-1:0]   flush_count_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } redir_state_e;

  redir_state_e     state_q, state_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             flush_hold_q, flush_hold_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             branch_accept;

  // Stall bus is purely combinational, so it tracks the requests even while
  // the sequential state is held in reset.
  stall_prio_enc u_stall_prio_enc (
    .if_req_i  (if_stall_req),
    .id_req_i  (id_stall_req),
    .ex_req_i  (ex_stall_req),
    .mem_req_i (mem_stall_req),
    .stall_o   (stall_state)
  );

  // Redirect FSM: a branch is only accepted when no redirect is outstanding;
  // a branch seen while one is pending is dropped so the first target sticks.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    branch_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_b_flag_i) begin
          branch_accept = 1'b1;
          redirect_pc_d = ex_b_target_i;
          state_d       = PEND;
        end
      end
      PEND: begin
        // The PC stage consumes the redirect on the first edge it is not held.
        if (!stall_state[STG_PC]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // While id_ex is frozen the squashed instructions sit in place, so the
  // flush must outlive the one-cycle branch flag until id_ex moves again.
  // A new set in the same cycle wins over the clear.
  always_comb begin
    flush_hold_d = stall_state[STG_ID_EX] & (ex_b_flag_i | flush_hold_q);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_state != STALL_NONE) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
    if (branch_accept) begin
      flush_count_d = sat_inc(flush_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      redirect_pc_q  <= '0;
      flush_hold_q   <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      redirect_pc_q  <= redirect_pc_d;
      flush_hold_q   <= flush_hold_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign flush_o          = ex_b_flag_i | flush_hold_q;
  assign redirect_valid_o = (state_q == PEND);
  assign redirect_pc_o    = redirect_pc_q;
  assign stall_cycles_o   = stall_cycles_q;
  assign flush_count_o    = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req;
  logic        id_stall_req;
  logic        ex_stall_req;
  logic        mem_stall_req;
  logic        ex_b_flag_i;
  logic [31:0] ex_b_target_i;
  logic [5:0]  stall_state;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic        m_pend;
  logic        m_hold;
  logic [31:0] m_pc;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_stall_req     (if_stall_req),
    .id_stall_req     (id_stall_req),
    .ex_stall_req     (ex_stall_req),
    .mem_stall_req    (mem_stall_req),
    .ex_b_flag_i      (ex_b_flag_i),
    .ex_b_target_i    (ex_b_target_i),
    .stall_state      (stall_state),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .stall_cycles_o   (stall_cycles_o),
    .flush_count_o    (flush_count_o)
  );

  always #5 clk = ~clk;

  // req = {mem, ex, id, if}; the deepest requesting stage freezes itself
  // and all stages before it, i.e. a run of ones of length stage+1.
  function automatic logic [5:0] m_stall(input logic [3:0] req);
    int depth;
    depth = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
    return 6'((1 << depth) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] req, input logic flag,
                            input logic [31:0] tgt);
    logic [5:0] s;
    s = m_stall(req);
    if (r) begin
      m_pend = 1'b0;
      m_hold = 1'b0;
      m_pc   = 32'h0;
      m_sc   = 32'h0;
      m_fc   = 32'h0;
    end else begin
      if (s != 6'h0 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'h1;
      m_hold = s[2] && (flag || m_hold);
      if (!m_pend) begin
        if (flag) begin
          m_pend = 1'b1;
          m_pc   = tgt;
          if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'h1;
        end
      end else if (!s[0]) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] req, input logic flag,
                       input logic [31:0] tgt);
    rst           = r;
    mem_stall_req = req[3];
    ex_stall_req  = req[2];
    id_stall_req  = req[1];
    if_stall_req  = req[0];
    ex_b_flag_i   = flag;
    ex_b_target_i = tgt;
  endtask

  // Called at a falling edge: drive, check outputs mid-cycle, take the
  // rising edge, advance the model, return at the next falling edge.
  task automatic cycle(input logic r, input logic [3:0] req, input logic flag,
                       input logic [31:0] tgt);
    drive(r, req, flag, tgt);
    #1;
    chk("stall_state", 32'(stall_state), 32'(m_stall(req)));
    chk("flush_o", 32'(flush_o), 32'(flag | m_hold));
    chk("redirect_valid_o", 32'(redirect_valid_o), 32'(m_pend));
    chk("redirect_pc_o", redirect_pc_o, m_pc);
    chk("stall_cycles_o", stall_cycles_o, m_sc);
    chk("flush_count_o", flush_count_o, m_fc);
    @(posedge clk);
    model_edge(r, req, flag, tgt);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rq;
    logic [31:0] fc_before;

    drive(1'b1, 4'b0000, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    m_pend = 1'b0;
    m_hold = 1'b0;
    m_pc   = 32'h0;
    m_sc   = 32'h0;
    m_fc   = 32'h0;
    @(negedge clk);

    // Reset state, and reset overriding a branch while stall bus follows inputs
    cycle(1'b1, 4'b0000, 1'b0, 32'h0);
    cycle(1'b1, 4'b1001, 1'b1, 32'hDEAD_BEEF);
    chk("rst_blocks_branch", 32'(redirect_valid_o), 32'h0);

    // Priority encoding
    cycle(1'b0, 4'b1001, 1'b0, 32'h0);
    chk("prio_mem_over_if", 32'(stall_state), 32'h1F);
    cycle(1'b0, 4'b0010, 1'b0, 32'h0);
    chk("prio_id_only", 32'(stall_state), 32'h07);

    // Branch with no stall
    cycle(1'b0, 4'b0000, 1'b1, 32'h0000_1040);
    chk("br_valid", 32'(redirect_valid_o), 32'h1);
    chk("br_pc", redirect_pc_o, 32'h0000_1040);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);
    chk("br_consumed", 32'(redirect_valid_o), 32'h0);
    chk("br_fcnt", flush_count_o, 32'h1);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);

    // Branch during a fetch stall
    cycle(1'b0, 4'b0000, 1'b1, 32'h0000_2468);
    repeat (3) cycle(1'b0, 4'b0001, 1'b0, 32'h0);
    chk("fetch_stall_held", 32'(redirect_valid_o), 32'h1);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);
    chk("fetch_stall_release", 32'(redirect_valid_o), 32'h0);

    // Flush hold across a decode stall
    cycle(1'b0, 4'b0010, 1'b1, 32'h0000_3000);
    repeat (2) cycle(1'b0, 4'b0010, 1'b0, 32'h0);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);
    chk("flush_hold_cleared", 32'(flush_o), 32'h0);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);

    // Second branch while pending is ignored
    cycle(1'b0, 4'b0001, 1'b1, 32'h0000_1111);
    fc_before = m_fc;
    cycle(1'b0, 4'b0001, 1'b1, 32'h0000_2000);
    chk("pend_pc_kept", redirect_pc_o, 32'h0000_1111);
    chk("pend_fcnt_kept", flush_count_o, fc_before);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) rq[k] = ($urandom_range(0, 3) == 0);
      cycle(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 2) == 0), $urandom);
    end

    // Stall counter saturation: preload near the top through a quiet edge
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.stall_cycles_q;
    model_edge(1'b0, 4'b0000, 1'b0, 32'h0);
    m_sc = 32'hFFFF_FFFE;
    @(negedge clk);
    repeat (3) cycle(1'b0, 4'b0001, 1'b0, 32'h0);
    chk("stall_cnt_saturated", stall_cycles_o, 32'hFFFF_FFFF);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);

    // Reset while a redirect is pending
    cycle(1'b0, 4'b0001, 1'b1, 32'h0000_4000);
    chk("pend_before_rst", 32'(redirect_valid_o), 32'h1);
    cycle(1'b1, 4'b0001, 1'b0, 32'h0);
    chk("rst_pend_valid", 32'(redirect_valid_o), 32'h0);
    chk("rst_pend_scnt", stall_cycles_o, 32'h0);
    chk("rst_pend_fcnt", flush_count_o, 32'h0);
    cycle(1'b0, 4'b0000, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use clock clk (input, 1 bit; all state updates on its rising edge).
REQ-002 The block SHALL use reset rst (input, 1 bit; synchronous, active-high).
REQ-003 The block SHALL have input if_stall_req, 1 bit: fetch not complete.
REQ-004 The block SHALL have input id_stall_req, 1 bit: load-use hazard in decode.
REQ-005 The block SHALL have input ex_stall_req, 1 bit: multi-cycle execute.
REQ-006 The block SHALL have input mem_stall_req, 1 bit: memory access not complete.
REQ-007 The block SHALL have input ex_b_flag_i, 1 bit: taken branch/jump resolved in EX.
REQ-008 The block SHALL have input ex_b_target_i, 32 bits: redirect address paired with ex_b_flag_i.
REQ-009 The block SHALL have output stall_state, `StallBus (6 bits): bit k=1 holds stage k (0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 wb).
REQ-010 The block SHALL have output flush_o, 1 bit: squash contents of if_id and id_ex.
REQ-011 The block SHALL have output redirect_valid_o, 1 bit: pending PC redirect.
REQ-012 The block SHALL have output redirect_pc_o, 32 bits: redirect target.
REQ-013 The block SHALL have outputs stall_cycles_o and flush_count_o, 32 bits each: performance counters.

Function
REQ-014 stall_state SHALL be combinational, decided by the highest-priority request: mem 6'b011111; else ex 6'b001111; else id 6'b000111; else if 6'b000011; else 6'b000000.
REQ-015 stall_state[5] SHALL always be 0.
REQ-016 The redirect FSM SHALL have exactly two states, IDLE and PEND.
REQ-017 IDLE + ex_b_flag_i=1: at the edge, latch ex_b_target_i into redirect_pc_o and go to PEND.
REQ-018 In PEND, redirect_valid_o SHALL be 1; in IDLE it SHALL be 0.
REQ-019 PEND: at the first edge with stall_state[0]=0 the redirect is consumed; go to IDLE.
REQ-020 PEND with stall_state[0]=1: hold state and redirect_pc_o unchanged.
REQ-021 ex_b_flag_i in PEND SHALL be ignored (target not overwritten) and SHALL NOT increment flush_count_o.
REQ-022 flush_o SHALL equal ex_b_flag_i OR flush_hold.
REQ-023 flush_hold SHALL be set at an edge where ex_b_flag_i=1 and stall_state[2]=1, and cleared at the first later edge where stall_state[2]=0.
REQ-024 When set and clear of flush_hold coincide, set SHALL win.
REQ-025 stall_cycles_o SHALL increment by 1 at each edge where stall_state≠0, saturating at 32'hFFFFFFFF.
REQ-026 flush_count_o SHALL increment by 1 at each edge where ex_b_flag_i is accepted in IDLE, saturating at 32'hFFFFFFFF.
REQ-027 redirect_valid_o SHALL be asserted no later than one cycle after an accepted ex_b_flag_i.

Reset
REQ-028 On rst=1 at an edge, the block SHALL go to IDLE and set redirect_pc_o, flush_hold, stall_cycles_o and flush_count_o to 0.
REQ-029 rst SHALL take priority over every other event.
REQ-030 Reset in PEND SHALL discard the pending redirect without it being consumed.
REQ-031 stall_state SHALL follow its inputs during reset.

Structure
REQ-032 `StallBus, the stage index constants and the stall pattern constants SHALL live in the shared defines.v.
REQ-033 FSM state encodings SHALL be local to the module.
REQ-034 The priority encoder SHALL be one sub-module, stall_prio_enc (4 requests in, 6-bit stall_state out, purely combinational).

Verification
REQ-035 Priority: mem_stall_req=1 and if_stall_req=1 -> stall_state=6'b011111; only id_stall_req=1 -> 6'b000111.
REQ-036 Branch with no stall: ex_b_flag_i=1, target 32'h0000_1040 -> flush_o=1 in that cycle; next cycle redirect_valid_o=1 and redirect_pc_o=32'h1040; following cycle redirect_valid_o=0; flush_count_o=1.
REQ-037 Branch during fetch stall: if_stall_req=1 for 3 cycles after ex_b_flag_i -> redirect_valid_o held 3 cycles; IDLE on the first edge with if_stall_req=0.
REQ-038 Flush hold: ex_b_flag_i=1 with id_stall_req=1, id_stall_req held 2 more cycles -> flush_o stays 1 until the first edge with stall_state[2]=0, then 0.
REQ-039 Second ex_b_flag_i in PEND with target 32'h2000 -> redirect_pc_o keeps its first value and flush_count_o is unchanged.
REQ-040 Saturation and reset: preload stall_cycles_o to 32'hFFFFFFFE, stall 3 cycles -> stays 32'hFFFFFFFF; rst in PEND -> redirect_valid_o=0 and both counters 0 next cycle.
